// File: rtl/dm_cache_controller.sv
// Sequencing FSM for a direct-mapped data cache: initial valid sweep, tag lookup,
// word-by-word block refill from main memory, tag update and hit/access statistics.
module dm_cache_controller #(
  parameter int ADDR_W = 15,
  parameter int IDX_W  = 10,
  parameter int OFS_W  = 2,
  parameter int CNT_W  = 16,
  localparam int TAG_W = ADDR_W - IDX_W - OFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  output logic              req_ready,
  output logic              hit_OUT,
  output logic              finish_OUT,
  output logic [IDX_W-1:0]  cache_index,
  input  logic [TAG_W-1:0]  tag_rd,
  input  logic              valid_rd,
  output logic              tag_we,
  output logic              valid_clr,
  output logic [OFS_W-1:0]  word_sel,
  output logic              data_we,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_FILL, S_UPDATE, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_init_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [OFS_W-1:0]   r_w;
  logic               r_finish;
  logic               r_hit_out;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic [CNT_W-1:0]   r_acc_cnt;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic               w_lookup_hit;

  assign w_tag        = r_addr[ADDR_W-1:IDX_W+OFS_W];
  assign w_idx        = r_addr[IDX_W+OFS_W-1:OFS_W];
  assign w_lookup_hit = valid_rd && (tag_rd == w_tag);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    valid_clr   = 1'b0;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    mem_rd      = 1'b0;
    cache_index = w_idx;
    word_sel    = '0;
    mem_addr    = '0;
    case (r_state)
      S_INIT: begin
        valid_clr   = 1'b1;
        cache_index = r_init_cnt;
        if (&r_init_cnt) w_next = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req) w_next = S_LOOKUP;
      end
      S_LOOKUP: w_next = w_lookup_hit ? S_DONE : S_FILL;
      S_FILL: begin
        mem_rd   = 1'b1;
        mem_addr = {w_tag, w_idx, r_w};
        word_sel = r_w;
        if (mem_ready) begin
          data_we = 1'b1;
          if (&r_w) w_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        tag_we = 1'b1;
        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_addr     <= '0;
      r_w        <= '0;
      r_finish   <= 1'b0;
      r_hit_out  <= 1'b0;
      r_hit_cnt  <= '0;
      r_acc_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_finish  <= (w_next == S_DONE);
      // The hit flag lives only for the DONE cycle; a refill always finishes as a miss.
      r_hit_out <= (r_state == S_LOOKUP) && w_lookup_hit;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (r_state == S_IDLE && req) r_addr <= address;
      if (r_state == S_LOOKUP) r_w <= '0;
      if (r_state == S_FILL && mem_ready && !(&r_w)) r_w <= r_w + 1'b1;
      if (r_state == S_DONE) begin
        if (!(&r_acc_cnt)) r_acc_cnt <= r_acc_cnt + 1'b1;
        if (r_hit_out && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + 1'b1;
      end
    end
  end

  assign finish_OUT   = r_finish;
  assign hit_OUT      = r_hit_out;
  assign hit_count    = r_hit_cnt;
  assign access_count = r_acc_cnt;

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench for dm_cache_controller with behavioural tag/valid array and
// variable-latency memory models.
module tb_dm_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [14:0] address;
  logic        req_ready, hit_OUT, finish_OUT;
  logic [9:0]  cache_index;
  logic [2:0]  tag_rd;
  logic        valid_rd;
  logic        tag_we, valid_clr, data_we, mem_rd, mem_ready;
  logic [1:0]  word_sel;
  logic [14:0] mem_addr;
  logic [15:0] hit_count, access_count;

  dm_cache_controller dut (
    .clk(clk), .rst(rst), .req(req), .address(address), .req_ready(req_ready),
    .hit_OUT(hit_OUT), .finish_OUT(finish_OUT), .cache_index(cache_index),
    .tag_rd(tag_rd), .valid_rd(valid_rd), .tag_we(tag_we), .valid_clr(valid_clr),
    .word_sel(word_sel), .data_we(data_we), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .hit_count(hit_count), .access_count(access_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Tag/valid array model; the written tag is the tag of the request in flight.
  logic [2:0] tag_arr [1024];
  logic       val_arr [1024];
  logic [2:0] cur_tag;
  int         tagwe_total = 0;
  logic [9:0] tagwe_idx;
  assign tag_rd   = tag_arr[cache_index];
  assign valid_rd = val_arr[cache_index];

  always @(posedge clk) begin
    if (valid_clr) val_arr[cache_index] <= 1'b0;
    if (tag_we) begin
      tag_arr[cache_index] <= cur_tag;
      val_arr[cache_index] <= 1'b1;
      tagwe_total          <= tagwe_total + 1;
      tagwe_idx            <= cache_index;
    end
  end

  // Memory model: mem_ready after mem_delay waiting cycles per word.
  int          mem_delay;
  int          wcnt = 0;
  logic [14:0] mem_log [$];
  int          ws_err = 0;
  int          stab_err = 0;
  logic        prev_pend = 1'b0;
  logic [14:0] prev_addr;
  assign mem_ready = mem_rd && (wcnt >= mem_delay);

  always @(posedge clk) begin
    wcnt      <= (mem_rd && !mem_ready) ? wcnt + 1 : 0;
    prev_pend <= mem_rd && !mem_ready;
    prev_addr <= mem_addr;
    if (prev_pend && mem_rd && mem_addr != prev_addr) stab_err <= stab_err + 1;
    if (mem_rd && mem_ready) begin
      mem_log.push_back(mem_addr);
      if (word_sel != mem_addr[1:0] || !data_we) ws_err <= ws_err + 1;
    end
  end

  int acc_log0;
  int acc_tagwe0;

  task automatic run_init(output int k, output int serr);
    @(negedge clk);
    rst = 1'b1;
    #1;
    k = 0;
    serr = 0;
    while (!req_ready && k < 2000) begin
      if (!valid_clr || cache_index != k[9:0]) serr++;
      k++;
      @(negedge clk);
      #1;
    end
    req = 1'b0;
  endtask

  task automatic do_access(input logic [14:0] a, output logic hit, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    acc_log0   = mem_log.size();
    acc_tagwe0 = tagwe_total;
    cur_tag    = a[14:12];
    address    = a;
    req        = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && req_ready) check("ready_drop", 32'd1, 32'd0);
    end while (!finish_OUT && lat < 300);
    if (!finish_OUT) check("finish_timeout", 32'd0, 32'd1);
    hit = hit_OUT;
    @(negedge clk);
  endtask

  task automatic check_fill(input string tag, input logic [14:0] base);
    check({tag, "_nwords"}, mem_log.size() - acc_log0, 32'd4);
    for (int i = 0; i < 4; i++)
      if (acc_log0 + i < mem_log.size())
        check({tag, "_addr"}, mem_log[acc_log0+i], base + 15'(i));
  endtask

  logic h;
  int   lat, k, serr, sw_err, n;

  initial begin
    mem_delay = 0;
    req       = 1'b0;
    address   = 15'd1024;
    rst       = 1'b0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid_clr", valid_clr, 1);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_finish", finish_OUT, 0);
    check("rst_access_cnt", access_count, 0);

    req = 1'b1;
    run_init(k, serr);
    check("init_cycles", k, 1024);
    check("init_sweep_err", serr, 0);

    do_access(15'd1024, h, lat);
    check("m1024_hit", h, 0);
    check("m1024_lat", lat, 7);
    check_fill("m1024", 15'd1024);
    check("m1024_tagwe_n", tagwe_total - acc_tagwe0, 1);
    check("m1024_tagwe_idx", tagwe_idx, 256);
    check("m1024_acc", access_count, 1);
    check("m1024_hits", hit_count, 0);

    do_access(15'd1025, h, lat);
    check("h1025_hit", h, 1);
    check("h1025_lat", lat, 2);
    check("h1025_no_mem", mem_log.size() - acc_log0, 0);
    check("h1025_hits", hit_count, 1);

    do_access(15'd5120, h, lat);
    check("m5120_hit", h, 0);
    check_fill("m5120", 15'd5120);
    check("m5120_tagwe_idx", tagwe_idx, 256);
    do_access(15'd1024, h, lat);
    check("evict1024_hit", h, 0);
    check("evict1024_lat", lat, 7);
    check("evict_acc", access_count, 4);
    check("evict_hits", hit_count, 1);

    // Fresh statistics for the sequential sweep.
    rst = 1'b0;
    #1 check("rst2_hits", hit_count, 0);
    run_init(k, serr);
    check("init2_cycles", k, 1024);
    sw_err = 0;
    for (int a = 1024; a <= 9215; a++) begin
      do_access(15'(a), h, lat);
      if (h != (a[1:0] != 2'd0)) sw_err++;
      if (lat != ((a[1:0] != 2'd0) ? 2 : 7)) sw_err++;
    end
    check("sweep_err", sw_err, 0);
    check("sweep_acc", access_count, 8192);
    check("sweep_hits", hit_count, 6144);
    check("mem_addr_stable", stab_err, 0);
    check("word_sel_err", ws_err, 0);

    // Reset during the second word of a slow refill.
    mem_delay = 3;
    while (!req_ready) @(negedge clk);
    acc_log0   = mem_log.size();
    acc_tagwe0 = tagwe_total;
    cur_tag    = 3'd0;
    address    = 15'd2048;
    req        = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    while (mem_log.size() < acc_log0 + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mf_word1_seen", mem_log.size() - acc_log0, 1);
    check("mf_rd_word2", mem_rd, 1);
    check("mf_addr_word2", mem_addr, 2049);
    #2 rst = 1'b0;
    #1;
    check("mf_rd_async_drop", mem_rd, 0);
    check("mf_valid_clr", valid_clr, 1);
    run_init(k, serr);
    check("init3_cycles", k, 1024);
    check("mf_no_tagwe", tagwe_total - acc_tagwe0, 0);
    do_access(15'd2048, h, lat);
    check("mf_rereq_hit", h, 0);
    check("mf_rereq_lat", lat, 19);
    check_fill("mf_rereq", 15'd2048);
    check("mf_acc", access_count, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
